// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the RV32M multiply/divide sequencer.
//   md_op_e    : funct3 encoding of the eight M-extension ops
//   md_state_e : sequencer states
//   MOST_NEG / ALL_ONES : signed-overflow and divide-by-zero constants at the default width
//   is_div(), is_signed() : op classification helpers
package muldiv_pkg;

  localparam int unsigned MD_DATA_WIDTH = 32;
  localparam logic [MD_DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(MD_DATA_WIDTH-1){1'b0}}};
  localparam logic [MD_DATA_WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  // True when rs1 is interpreted as signed. MUL is treated as unsigned since
  // the low half of the product does not depend on operand signedness.
  function automatic logic is_signed(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational two-lane conditional two's-complement negate.
// Used for magnitude extraction of operands and for sign fixing of results.
//   iA/iNegA -> oA : lane A (WA bits), negated when iNegA
//   iB/iNegB -> oB : lane B (WB bits), negated when iNegB
module muldiv_sign_fix #(
  parameter int unsigned WA = 32,
  parameter int unsigned WB = 32
) (
  input  logic [WA-1:0] iA,
  input  logic          iNegA,
  input  logic [WB-1:0] iB,
  input  logic          iNegB,
  output logic [WA-1:0] oA,
  output logic [WB-1:0] oB
);

  always_comb begin
    oA = iNegA ? -iA : iA;
    oB = iNegB ? -iB : iB;
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
//   iClk/iRstN        : clock (rising edge), asynchronous active-low reset
//   iValid/oReady     : op request handshake (accept = iValid & oReady & !iFlush)
//   iOp/iOp1/iOp2     : funct3 op code and rs1/rs2 operands
//   iFlush            : abort any in-flight op
//   oValid            : one-cycle result strobe
//   oResult/oZero     : registered result and (result == 0), held between completions
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = 3,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [OP_WIDTH-1:0]   iOp,
  input  logic [DATA_WIDTH-1:0] iOp1,
  input  logic [DATA_WIDTH-1:0] iOp2,
  input  logic                  iFlush,
  output logic                  oValid,
  output logic [DATA_WIDTH-1:0] oResult,
  output logic                  oZero
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [W-1:0] MostNeg = {1'b1, {(W-1){1'b0}}};

  md_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  md_op_e               op_q;
  logic [2*W-1:0]       work_q;   // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]         opb_q;    // mul: multiplicand; div: divisor
  logic                 negq_q, negr_q;
  logic [W-1:0]         res_q, res_d;
  logic                 zero_q, res_load;

  md_op_e         op_in;
  logic           accept, s1, s2, div0, ovf, special;
  logic [W-1:0]   mag1, mag2, spec_res, calc_res, fixed_b;
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] work_nxt, fix_a, fixed_a;
  md_op_e         fix_op;
  logic           fix_nega;

  assign op_in   = md_op_e'(iOp);
  assign oReady  = (state_q == IDLE) || (state_q == DONE);
  assign accept  = iValid && oReady && !iFlush;
  assign oValid  = (state_q == DONE);
  assign oResult = res_q;
  assign oZero   = zero_q;

  assign s1   = is_signed(op_in) & iOp1[W-1];
  assign s2   = is_signed(op_in) & (op_in != MD_MULHSU) & iOp2[W-1];
  assign div0 = (iOp2 == '0);
  assign ovf  = (op_in inside {MD_DIV, MD_REM}) && (iOp1 == MostNeg) && (iOp2 == '1);

`ifdef MULDIV_FAST_MUL_EN
  assign special = is_div(op_in) ? (div0 | ovf) : 1'b1;
`else
  assign special = is_div(op_in) & (div0 | ovf);
`endif

  muldiv_sign_fix #(.WA(W), .WB(W)) u_opnd_fix (
    .iA(iOp1), .iNegA(s1), .iB(iOp2), .iNegB(s2), .oA(mag1), .oB(mag2)
  );

  // One iteration step; the final step feeds the result path in the same
  // cycle so the result register loads on entry to DONE.
  always_comb begin
    mul_sum   = {1'b0, work_q[2*W-1:W]} + {1'b0, opb_q & {W{work_q[0]}}};
    div_shift = work_q[2*W-1:W-1];
    div_diff  = div_shift - {1'b0, opb_q};
    if (is_div(op_q)) begin
      if (!div_diff[W]) work_nxt = {div_diff[W-1:0], work_q[W-2:0], 1'b1};
      else              work_nxt = {div_shift[W-1:0], work_q[W-2:0], 1'b0};
    end else begin
      work_nxt = {mul_sum, work_q[W-1:1]};
    end
  end

  always_comb begin
    fix_op   = op_q;
    fix_a    = is_div(op_q) ? {{W{1'b0}}, work_nxt[W-1:0]} : work_nxt;
    fix_nega = negq_q;
`ifdef MULDIV_FAST_MUL_EN
    if (accept && !is_div(op_in)) begin
      fix_op   = op_in;
      fix_a    = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
      fix_nega = s1 ^ s2;
    end
`endif
  end

  muldiv_sign_fix #(.WA(2*W), .WB(W)) u_res_fix (
    .iA(fix_a), .iNegA(fix_nega), .iB(work_nxt[2*W-1:W]), .iNegB(negr_q),
    .oA(fixed_a), .oB(fixed_b)
  );

  always_comb begin
    unique case (fix_op)
      MD_MUL, MD_DIV, MD_DIVU:         calc_res = fixed_a[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:    calc_res = fixed_a[2*W-1:W];
      default:                         calc_res = fixed_b;
    endcase
  end

  always_comb begin
    spec_res = '0;
    if (div0)     spec_res = (op_in inside {MD_DIV, MD_DIVU}) ? '1 : iOp1;
    else if (ovf) spec_res = (op_in == MD_DIV) ? iOp1 : '0;
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div(op_in)) spec_res = calc_res;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_load = 1'b0;
    res_d    = calc_res;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (special) begin
            state_d  = DONE;
            res_load = 1'b1;
            res_d    = spec_res;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_WIDTH'(W - 1);
          end
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          res_load = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (iFlush) begin
      state_d  = IDLE;
      res_load = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      op_q    <= MD_MUL;
      opb_q   <= '0;
      work_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (res_load) begin
        res_q  <= res_d;
        zero_q <= (res_d == '0);
      end
      if (accept) begin
        op_q   <= op_in;
        negq_q <= s1 ^ s2;
        negr_q <= s1;
        if (is_div(op_in)) begin
          work_q <= {{W{1'b0}}, mag1};
          opb_q  <= mag2;
        end else begin
          work_q <= {{W{1'b0}}, mag2};
          opb_q  <= mag1;
        end
      end else if (state_q == CALC) begin
        work_q <= work_nxt;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq (result, zero flag, latency).
module tb_muldiv_seq;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int unsigned MulLat = 1;
`else
  localparam int unsigned MulLat = 33;
`endif
  localparam int unsigned DivLat = 33;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [2:0]  iOp = 3'b000;
  logic [31:0] iOp1 = '0;
  logic [31:0] iOp2 = '0;
  logic        iFlush = 1'b0;
  logic        oValid;
  logic [31:0] oResult;
  logic        oZero;

  muldiv_seq #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
    .iOp(iOp), .iOp1(iOp1), .iOp2(iOp2), .iFlush(iFlush),
    .oValid(oValid), .oResult(oResult), .oZero(oZero)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int unsigned acc;
    int unsigned lat;
    string       tag;
  } exp_t;

  exp_t        scb[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] last_exp = '0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] up;
    logic ov;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ov = (a == MOST_NEG) && (b == ALL_ONES);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: return (b == 0) ? ALL_ONES : ov ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? ALL_ONES : a / b;
      3'd6: return (b == 0) ? a : ov ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return MulLat;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == MOST_NEG && b == ALL_ONES) return 1;
    return DivLat;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit push);
    int unsigned guard;
    exp_t e;
    guard = 0;
    while (!oReady && guard < 100) begin
      @(posedge iClk); #1;
      guard++;
    end
    if (!oReady) check({tag, "_ready_timeout"}, 32'(oReady), 32'd1);
    iValid = 1'b1; iOp = op; iOp1 = a; iOp2 = b;
    if (push) begin
      e.res = exp; e.zero = (exp == 0); e.acc = cyc; e.lat = lat_of(op, a, b); e.tag = tag;
      scb.push_back(e);
    end
    @(posedge iClk); #1;
    iValid = 1'b0;
  endtask

  always @(negedge iClk) begin
    exp_t e;
    if (iRstN && oValid) begin
      if (scb.size() == 0) begin
        check("unexpected_valid", 32'(oValid), 32'd0);
      end else begin
        e = scb.pop_front();
        check({e.tag, "_res"}, oResult, e.res);
        check({e.tag, "_zero"}, 32'(oZero), 32'(e.zero));
        check({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
        last_exp = e.res;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int unsigned guard;
    int unsigned acc;

    #12;
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_ready", 32'(oReady), 32'd1);
    check("rst_result", oResult, 32'd0);
    check("rst_zero", 32'(oZero), 32'd1);
    #11 iRstN = 1'b1;
    @(posedge iClk); #1;

    do_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    do_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    do_op("divu_0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    do_op("remu_0", 3'd7, 32'd5, 32'd0, 32'd5, 1'b1);
    do_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    do_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);

    // Flush in CALC: accepted op must never strobe, result held.
    acc = cyc;
    do_op("divu_flushed", 3'd5, 32'd100, 32'd7, 32'd0, 1'b0);
    while (cyc < acc + 10) begin @(posedge iClk); #1; end
    check("flush_busy_ready", 32'(oReady), 32'd0);
    iFlush = 1'b1;
    @(posedge iClk); #1;
    iFlush = 1'b0;
    check("flush_ready", 32'(oReady), 32'd1);
    check("flush_hold", oResult, last_exp);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 1'b1);

    // Flush with a request in the same cycle: no accept.
    guard = 0;
    while (!oReady && guard < 100) begin @(posedge iClk); #1; guard++; end
    iValid = 1'b1; iFlush = 1'b1; iOp = 3'd5; iOp1 = 32'd100; iOp2 = 32'd7;
    @(posedge iClk); #1;
    iValid = 1'b0; iFlush = 1'b0;
    check("flush_wins_ready", 32'(oReady), 32'd1);

    // Asynchronous reset in cycle 5 of a multiply.
    acc = cyc;
    do_op("mul_reset", 3'd0, 32'd6, 32'd7, 32'd0, 1'b0);
    while (cyc < acc + 5) begin @(posedge iClk); #1; end
    iRstN = 1'b0;
    #1;
    check("midrst_valid", 32'(oValid), 32'd0);
    check("midrst_ready", 32'(oReady), 32'd1);
    check("midrst_result", oResult, 32'd0);
    check("midrst_zero", 32'(oZero), 32'd1);
    #3 iRstN = 1'b1;
    @(posedge iClk); #1;

    // Back-to-back: second op accepted in the DONE cycle of the first.
    do_op("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 1'b1);
    guard = 0;
    while (!oReady && guard < 100) begin @(posedge iClk); #1; guard++; end
    check("b2b_in_done", 32'(oValid), 32'd1);
    do_op("divu_12_4", 3'd5, 32'd12, 32'd4, 32'd3, 1'b1);

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 5 == 0) ? 32'd0 : (i % 3 == 1) ? 32'($urandom_range(1, 9)) : $urandom;
      do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), 1'b1);
    end

    guard = 0;
    while (scb.size() != 0 && guard < 200) begin @(posedge iClk); #1; guard++; end
    check("scb_drained", 32'(scb.size()), 32'd0);
    repeat (3) @(posedge iClk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer that sits beside the execute-stage ALU and owns all M-extension ops.
- Accepts one operation through a valid/ready handshake and runs a shift-add multiply or restoring divide over DATA_WIDTH cycles.
- Returns a registered result with a one-cycle valid pulse.
- Execute stage stalls on oReady low; iFlush aborts on branch mispredict or trap.

Parameters:
DATA_WIDTH, 32, operand/result width
OP_WIDTH, 3, op code width (funct3)
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width

Ports:
iClk  input  1  clock, rising edge
iRstN  input  1  asynchronous active-low reset
iValid  input  1  op request from execute stage
oReady  output  1  sequencer can accept
iOp  input  OP_WIDTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
iOp1  input  DATA_WIDTH  rs1 value
iOp2  input  DATA_WIDTH  rs2 value
iFlush  input  1  abort in-flight op
oValid  output  1  one-cycle result strobe
oResult  output  DATA_WIDTH  registered result, held until next completion
oZero  output  1  registered (oResult == 0)

Behaviour:
- Reset (iRstN low, async): state IDLE, counter 0, oValid 0, oResult 0, oZero 1, oReady 1.
- States:
  - IDLE/DONE -> CALC on accept.
  - IDLE/DONE -> DONE on special-case accept.
  - CALC -> DONE when counter reaches 0.
  - DONE -> IDLE otherwise.
  - Any state -> IDLE on iFlush.
- oReady = state is IDLE or DONE, so back-to-back ops are allowed.
- Accept is iValid & oReady & !iFlush. Operands and op are latched on the accept edge.
- Operand conditioning at accept:
  - Signed ops take magnitudes.
  - Result sign:
    - MULH, DIV: sign1 ^ sign2.
    - MULHSU: sign1 only; op2 is unsigned.
    - REM: sign1.
    - Unsigned ops: positive.
- Multiply: 2*DATA_WIDTH-bit product register, one shift-add per CALC cycle. MUL returns the low half; MULH/MULHSU/MULHU return the high half after sign fix of the full 2W product.
- Divide: restoring, one quotient bit per CALC cycle. DIV/DIVU return the quotient; REM/REMU return the remainder, both sign-fixed.
- Latency: accept in cycle 0. Counter starts at DATA_WIDTH-1 and decrements each CALC cycle. oValid is high in cycle DATA_WIDTH+1 (33 at default), for exactly one cycle.
- Special cases skip CALC; oValid is high in cycle 1:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = iOp1.
  - Signed overflow (iOp1 = most-negative, iOp2 = -1): DIV = iOp1; REM = 0.
- oResult and oZero update only on entry to DONE and are otherwise held.
- Flush:
  - iFlush in CALC: no oValid; state IDLE next cycle; oResult keeps its old value.
  - iFlush with iValid in the same cycle: flush wins, no accept.
  - iFlush in DONE: suppresses nothing already strobed; state returns to IDLE.
- Reset asserted mid-CALC: immediate return to reset values; no oValid.
- Widths: all arithmetic is unsigned on magnitudes. Negation is two's complement at DATA_WIDTH (or 2*DATA_WIDTH for the product). No X on oResult in any state.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: the four multiply ops use a single-cycle combinational multiplier. Accept goes straight to DONE, so oValid is in cycle 1. Divide is unchanged.
- Undefined: all multiplies are iterative (DATA_WIDTH+1 latency); no hardware multiplier is inferred.

Decomposition:
- Package muldiv_pkg:
  - op enum (MD_MUL..MD_REMU, funct3 encoding)
  - state enum (IDLE, CALC, DONE)
  - constants MOST_NEG and ALL_ONES derived from DATA_WIDTH
  - helper is_div(op) and is_signed(op) functions
- One sub-module: muldiv_sign_fix. It is combinational and handles magnitude extraction and result negation. It is instantiated twice: once for operand conditioning, once for the result.

Test Plan:
- MUL iOp1=7, iOp2=0xFFFFFFFD -> oValid in cycle 33, oResult=0xFFFFFFEB, oZero=0.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. Then MULH on the same operands -> 0x00000000, oZero=1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1. REM on the same operands -> 0 in cycle 1.
- DIVU 5 / 0 -> 0xFFFFFFFF in cycle 1. REMU 5 / 0 -> 5. REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
- DIVU 100 / 7 accepted, then iFlush in cycle 10 -> no oValid ever, oReady=1 in cycle 11, oResult unchanged. A new DIVU 100 / 7 -> 14.
- iRstN pulsed low in cycle 5 of a MUL -> oValid=0, oReady=1, oResult=0 immediately. Then back-to-back MUL 3x4 and DIVU 12/4 accepted in DONE -> results 12, then 3.
